// File: rtl/vdma_pkg.sv
// vdma_pkg - shared definitions for the VDMA read path.
//   VDMA_DSIZE : default AXI read-data / beat width
//   VDMA_DEPTH : default beat FIFO depth (power of two, >= 4)
//   ptr_w()    : pointer width including the wrap bit
//   rd_beat_t  : stored beat {last, data} at the default width
package vdma_pkg;

    localparam int unsigned VDMA_DSIZE = 256;
    localparam int unsigned VDMA_DEPTH = 16;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic                  last;
        logic [VDMA_DSIZE-1:0] data;
    } rd_beat_t;

endpackage

// File: rtl/rd_fifo_ptr.sv
// rd_fifo_ptr - read/write pointer pair and status for axi_rd_beat_fifo.
// Ports:
//   clock, rst (sync, active-high), flush (clears both pointers)
//   wr_req   : upstream beat valid        wr_ready : beat can be taken
//   wr_en    : beat accepted this cycle   wr_addr  : slot to write
//   rd_req   : pop request from consumer  rd_addr  : head slot
//   empty, afull, level : derived from registered pointers only
module rd_fifo_ptr
    import vdma_pkg::*;
#(
    parameter int unsigned DEPTH     = VDMA_DEPTH,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_req,
    input  logic                     rd_req,
    output logic                     wr_ready,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     empty,
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          full;
    logic          rd_en;

    // Wrap bit distinguishes full (MSBs differ, low bits equal) from empty.
    always_comb begin
        full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
        empty    = (wp == rp);
        level    = wp - rp;
        afull    = (level >= PW'(AFULL_LVL));
        wr_ready = ~full & ~flush & ~rst;
        wr_en    = wr_req & wr_ready;
        rd_en    = rd_req & ~empty & ~flush & ~rst;
        wr_addr  = wp[AW-1:0];
        rd_addr  = rp[AW-1:0];
    end

    always_ff @(posedge clock) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_beat_fifo.sv
// axi_rd_beat_fifo - show-ahead beat buffer between the AXI4 R channel and
// the VDMA width splitter. The head beat is always presented on idata/ilast.
// Ports:
//   clock, rst (sync, active-high), flush (frame restart, drops all beats)
//   axi_rvalid/axi_rready/axi_rdata/axi_rlast : AXI R beat input
//   ird_en : pop head beat          idata/ilast : head beat and its last flag
//   ialign : one-cycle pulse when the first beat after reset/flush reaches head
//   empty, afull, level : occupancy status
// Build option: define AXI_RD_BEAT_FIFO_ERR_EN to add a sticky underflow
// flag output `err` (cleared by rst or flush).
module axi_rd_beat_fifo
    import vdma_pkg::*;
#(
    parameter int unsigned DSIZE     = VDMA_DSIZE,
    parameter int unsigned DEPTH     = VDMA_DEPTH,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   axi_rvalid,
    output logic                   axi_rready,
    input  logic [DSIZE-1:0]       axi_rdata,
    input  logic                   axi_rlast,
    input  logic                   ird_en,
    output logic [DSIZE-1:0]       idata,
    output logic                   ilast,
    output logic                   ialign,
    output logic                   empty,
    output logic                   afull,
    output logic [$clog2(DEPTH):0] level
`ifdef AXI_RD_BEAT_FIFO_ERR_EN
    ,
    output logic                   err
`endif
);

    typedef struct packed {
        logic             last;
        logic [DSIZE-1:0] data;
    } beat_t;

    logic                     wr_en;
    logic [$clog2(DEPTH)-1:0] wr_addr;
    logic [$clog2(DEPTH)-1:0] rd_addr;
    logic                     first_pend;
    beat_t                    mem [DEPTH];

    rd_fifo_ptr #(
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL_LVL)
    ) u_ptr (
        .clock    (clock),
        .rst      (rst),
        .flush    (flush),
        .wr_req   (axi_rvalid),
        .rd_req   (ird_en),
        .wr_ready (axi_rready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .empty    (empty),
        .afull    (afull),
        .level    (level)
    );

    // Storage needs no reset: content is only visible while non-empty.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= '{last: axi_rlast, data: axi_rdata};
    end

    always_comb begin
        idata = mem[rd_addr].data;
        ilast = mem[rd_addr].last;
    end

    // The first beat accepted after reset/flush lands in an empty FIFO, so
    // the cycle after its acceptance is exactly when it sits at head.
    always_ff @(posedge clock) begin
        if (rst || flush) begin
            first_pend <= 1'b1;
            ialign     <= 1'b0;
        end else begin
            ialign <= wr_en & first_pend;
            if (wr_en) first_pend <= 1'b0;
        end
    end

`ifdef AXI_RD_BEAT_FIFO_ERR_EN
    always_ff @(posedge clock) begin
        if (rst || flush) begin
            err <= 1'b0;
        end else if (ird_en && empty) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_beat_fifo.sv
module tb_axi_rd_beat_fifo;

    localparam int DSIZE = 256;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic                   clock = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   axi_rvalid;
    logic                   axi_rready;
    logic [DSIZE-1:0]       axi_rdata;
    logic                   axi_rlast;
    logic                   ird_en;
    logic [DSIZE-1:0]       idata;
    logic                   ilast;
    logic                   ialign;
    logic                   empty;
    logic                   afull;
    logic [$clog2(DEPTH):0] level;
`ifdef AXI_RD_BEAT_FIFO_ERR_EN
    logic                   err;
`endif

    always #5 clock = ~clock;

    axi_rd_beat_fifo #(
        .DSIZE     (DSIZE),
        .DEPTH     (DEPTH),
        .AFULL_LVL (AFULL)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .flush      (flush),
        .axi_rvalid (axi_rvalid),
        .axi_rready (axi_rready),
        .axi_rdata  (axi_rdata),
        .axi_rlast  (axi_rlast),
        .ird_en     (ird_en),
        .idata      (idata),
        .ilast      (ilast),
        .ialign     (ialign),
        .empty      (empty),
        .afull      (afull),
        .level      (level)
`ifdef AXI_RD_BEAT_FIFO_ERR_EN
        ,
        .err        (err)
`endif
    );

    // Reference model: occupancy count plus a queue of expected beats.
    int               n_chk  = 0;
    int               n_fail = 0;
    int               occ    = 0;
    bit               pend   = 1'b1;
    bit               exp_align = 1'b0;
    bit               exp_err   = 1'b0;
    bit               mon_en    = 1'b0;
    logic [DSIZE:0]   sbq [$];

    task automatic check(input string name, input logic [DSIZE:0] act, input logic [DSIZE:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model update on each active edge, from the inputs presented before it.
    initial forever begin
        @(posedge clock);
        if (rst || flush) begin
            occ = 0;
            sbq.delete();
            pend = 1'b1;
            exp_align = 1'b0;
            exp_err = 1'b0;
        end else begin
            bit acc, pp;
            acc = axi_rvalid && (occ < DEPTH);
            pp  = ird_en && (occ > 0);
            if (ird_en && occ == 0) exp_err = 1'b1;
            exp_align = acc && pend;
            if (acc) begin
                sbq.push_back({axi_rlast, axi_rdata});
                pend = 1'b0;
            end
            occ = occ + int'(acc) - int'(pp);
        end
    end

    // Monitor: status every cycle; head beat compared while present and
    // retired from the scoreboard when the consumer takes it.
    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            check("axi_rready", {{DSIZE{1'b0}}, axi_rready}, {{DSIZE{1'b0}}, (occ < DEPTH) && !flush && !rst});
            check("empty", {{DSIZE{1'b0}}, empty}, {{DSIZE{1'b0}}, occ == 0});
            check("level", (DSIZE+1)'(level), (DSIZE+1)'(occ));
            check("afull", {{DSIZE{1'b0}}, afull}, {{DSIZE{1'b0}}, occ >= AFULL});
            check("ialign", {{DSIZE{1'b0}}, ialign}, {{DSIZE{1'b0}}, exp_align});
`ifdef AXI_RD_BEAT_FIFO_ERR_EN
            check("err", {{DSIZE{1'b0}}, err}, {{DSIZE{1'b0}}, exp_err});
`endif
            if (!empty) begin
                if (sbq.size() == 0) begin
                    check("head_present", {{DSIZE{1'b0}}, 1'b1}, '0);
                end else begin
                    check("head_beat", {ilast, idata}, sbq[0]);
                    if (ird_en && !flush && !rst) void'(sbq.pop_front());
                end
            end
        end
    end

    function automatic logic [DSIZE-1:0] rand_beat();
        logic [DSIZE-1:0] d;
        for (int k = 0; k < DSIZE / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock of stimulus; inputs change 1 time unit after the active edge.
    task automatic cyc(input logic rv, input logic [DSIZE-1:0] d, input logic l,
                       input logic rd, input logic fl, input logic r, output logic took);
        axi_rvalid = rv;
        axi_rdata  = d;
        axi_rlast  = l;
        ird_en     = rd;
        flush      = fl;
        rst        = r;
        #1;
        took = rv & axi_rready;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic             took;
        logic [DSIZE-1:0] cnt;

        rst = 1'b1; flush = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0;
        axi_rlast = 1'b0; ird_en = 1'b0;
        cyc(0, '0, 0, 0, 0, 1, took);
        mon_en = 1'b1;
        cyc(0, '0, 0, 0, 0, 1, took);
        cyc(0, '0, 0, 0, 0, 1, took);

        // Three back-to-back beats after reset.
        for (int i = 1; i <= 3; i++) cyc(1, DSIZE'(i), 0, 0, 0, 0, took);
        repeat (2) cyc(0, '0, 0, 0, 0, 0, took);
        repeat (4) cyc(0, '0, 0, 1, 0, 0, took);
        cyc(0, '0, 0, 0, 1, 0, took);

        // Fill to full, hold the next beat until one pop frees a slot.
        cnt = DSIZE'(32'h100);
        for (int i = 0; i < 20; i++) begin
            cyc(1, cnt, 0, 0, 0, 0, took);
            if (took) cnt = cnt + 1'b1;
        end
        cyc(1, cnt, 0, 1, 0, 0, took);
        if (took) cnt = cnt + 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1, cnt, 0, 0, 0, 0, took);
            if (took) cnt = cnt + 1'b1;
        end
        repeat (18) cyc(0, '0, 0, 1, 0, 0, took);

        // Streaming: write and pop every cycle, wrapping the pointers.
        cnt = DSIZE'(32'h200);
        for (int i = 0; i < 42; i++) begin
            cyc(1, cnt, 0, (i >= 2), 0, 0, took);
            if (took) cnt = cnt + 1'b1;
        end
        repeat (4) cyc(0, '0, 0, 1, 0, 0, took);

        // Eight-beat burst with last on the final beat, popped slowly.
        for (int i = 0; i < 8; i++) cyc(1, rand_beat(), (i == 7), 0, 0, 0, took);
        for (int i = 0; i < 18; i++) cyc(0, '0, 0, i[0], 0, 0, took);

        // Flush at level 5 with a beat offered in the same cycle.
        for (int i = 0; i < 5; i++) cyc(1, rand_beat(), 0, 0, 0, 0, took);
        cyc(1, rand_beat(), 1, 1, 1, 0, took);
        cyc(1, rand_beat(), 0, 0, 0, 0, took);
        repeat (2) cyc(0, '0, 0, 0, 0, 0, took);
        repeat (3) cyc(0, '0, 0, 1, 0, 0, took);

        // Pops while empty, then flush clears the underflow condition.
        repeat (2) cyc(0, '0, 0, 1, 0, 0, took);
        repeat (3) cyc(0, '0, 0, 0, 0, 0, took);
        cyc(0, '0, 0, 0, 1, 0, took);
        cyc(0, '0, 0, 0, 0, 0, took);

        // Random traffic with occasional flush and mid-burst reset.
        for (int i = 0; i < 800; i++) begin
            logic rv, rd, fl, r;
            rv = ($urandom_range(0, 3) != 0);
            rd = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 127) == 0);
            cyc(rv, rand_beat(), $urandom_range(0, 1) == 1, rd, fl, r, took);
        end
        repeat (20) cyc(0, '0, 0, 1, 0, 0, took);
        repeat (2) cyc(0, '0, 0, 0, 0, 0, took);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
